// File: rtl/row_scanner_if.sv
// -----------------------------------------------------------------------------
// row_scanner_if
//
// Row-buffer side of the scanner. It carries the read port, the clear/write
// port and the pacing pulses that go to the drawer.
//
//   address_read_row  [8:0]  row-buffer read address
//   read_buffer              bank being scanned out
//   data_read_row     [23:0] read data {R,G,B}, registered RAM, 1-cycle latency
//   address_clear_row [8:0]  clear write address
//   clear_buffer             bank targeted by the clear write
//   clear_we                 clear write enable
//   data_clear_row    [23:0] clear write data (background colour)
//   swap                     1-clk pulse: drawer advances to the next row
//   swap_screen              1-clk pulse: drawer restarts at row 0
//   draw_buffer              bank the drawer writes, always ~read_buffer
//
// The master modport is the scanner. The slave modport is the buffer and
// drawer side.
// -----------------------------------------------------------------------------
interface row_scanner_if;
    logic [8:0]  address_read_row;
    logic        read_buffer;
    logic [23:0] data_read_row;
    logic [8:0]  address_clear_row;
    logic        clear_buffer;
    logic        clear_we;
    logic [23:0] data_clear_row;
    logic        swap;
    logic        swap_screen;
    logic        draw_buffer;

    modport master (
        output address_read_row,
        output read_buffer,
        input  data_read_row,
        output address_clear_row,
        output clear_buffer,
        output clear_we,
        output data_clear_row,
        output swap,
        output swap_screen,
        output draw_buffer
    );

    modport slave (
        input  address_read_row,
        input  read_buffer,
        output data_read_row,
        input  address_clear_row,
        input  clear_buffer,
        input  clear_we,
        input  data_clear_row,
        input  swap,
        input  swap_screen,
        input  draw_buffer
    );
endinterface

// File: rtl/row_scanner.sv
// -----------------------------------------------------------------------------
// row_scanner
//
// This is the read-side counterpart to the row drawer. It generates display
// timing at one pixel per clk. It scans out the double-buffered 24-bit row
// buffer and drives RGB, sync and blank to the DAC. It also paces the drawer
// with the swap and swap_screen pulses. After a row has been scanned out, the
// scanner clears it back to the background colour.
//
// Ports
//   clk                  pixel clock
//   reset                synchronous, active-high
//   rb                   row-buffer and drawer bus (row_scanner_if.master)
//   red/green/blue [7:0] pixel colour; 0 outside the active area
//   hsync, vsync         active-low sync, aligned with the pixel
//   blank                high outside the active area, aligned with the pixel
//
// Pipeline
//   stage 0 (counters)   the read address is presented
//   stage 1              RAM data returns, and this pixel's clear write is issued
//   stage 2              RGB, sync and blank are registered
// -----------------------------------------------------------------------------
module row_scanner #(
    parameter int          H_ACTIVE = 320,
    parameter int          H_FP     = 8,
    parameter int          H_SYNC   = 48,
    parameter int          H_BP     = 24,
    parameter int          V_ACTIVE = 240,
    parameter int          V_FP     = 3,
    parameter int          V_SYNC   = 4,
    parameter int          V_BP     = 15,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic          clk,
    input  logic          reset,
    row_scanner_if.master rb,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
    output logic          hsync,
    output logic          vsync,
    output logic          blank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SWAPMAX = VW'(V_ACTIVE - 2);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_CLR_A   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_CLR_B   = VW'(V_ACTIVE + 1);
    localparam logic [8:0]    CLR_LAST  = 9'(H_ACTIVE - 1);

    localparam logic [1:0] ST_SCAN  = 2'd0;
    localparam logic [1:0] ST_CLR_A = 2'd1;
    localparam logic [1:0] ST_CLR_B = 2'd2;

    logic [HW-1:0] h_count, h_next;
    logic [VW-1:0] v_count, v_next;
    logic [1:0]    state;
    logic [8:0]    clr_cnt;
    logic          read_bank;
    logic          pace_next;
    logic          active0, hs0, vs0;
    logic          active_d1;
    logic          hs_d1, vs_d1, blank_d1;
    logic          hs_q, vs_q, blank_q;
    logic [23:0]   rgb_q;
    logic          clr_we_q, clr_bank_q;
    logic [8:0]    clr_addr_q;

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        h_next = h_count + HW'(1);
        v_next = v_count;
        if (h_count == H_LAST) begin
            h_next = '0;
            v_next = (v_count == V_LAST) ? '0 : v_count + VW'(1);
        end
    end

    // The bank flips on the clock edge that enters a pacing cycle. This way
    // read_buffer already holds the new bank during the pulse cycle and for the
    // whole line that follows, including the pixel-0 read at h_count 0.
    assign pace_next = (h_next == '0) && ((v_next <= V_SWAPMAX) || (v_next == V_LAST));

    assign active0 = (h_count < H_ACT_C) && (v_count < V_ACT_C);
    assign hs0     = !((h_count >= HS_START) && (h_count < HS_END));
    assign vs0     = !((v_count >= VS_START) && (v_count < VS_END));

    // The pulses decode the live counters so that the first one lands on clk 0
    // of line 0 after reset. They are gated by reset, because the counters
    // already sit at (0,0) while reset is held.
    assign rb.swap        = !reset && (h_count == '0) && (v_count <= V_SWAPMAX);
    assign rb.swap_screen = !reset && (h_count == '0) && (v_count == V_LAST);

    assign rb.address_read_row  = active0 ? 9'(h_count) : 9'd0;
    assign rb.read_buffer       = read_bank;
    assign rb.draw_buffer       = ~read_bank;
    assign rb.address_clear_row = clr_addr_q;
    assign rb.clear_buffer      = clr_bank_q;
    assign rb.clear_we          = clr_we_q;
    assign rb.data_clear_row    = BG_COLOR;

    assign red   = rgb_q[23:16];
    assign green = rgb_q[15:8];
    assign blue  = rgb_q[7:0];
    assign hsync = hs_q;
    assign vsync = vs_q;
    assign blank = blank_q;

    // NOTE: all state here updates with non-blocking assignments. Every register
    // then samples values from before the edge, and the stage delays line up.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count    <= '0;
            v_count    <= '0;
            read_bank  <= 1'b0;
            state      <= ST_SCAN;
            clr_cnt    <= '0;
            clr_we_q   <= 1'b0;
            clr_addr_q <= '0;
            clr_bank_q <= 1'b0;
            active_d1  <= 1'b0;
            hs_d1      <= 1'b1;
            vs_d1      <= 1'b1;
            blank_d1   <= 1'b1;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_q    <= 1'b1;
            rgb_q      <= '0;
        end else begin
            h_count <= h_next;
            v_count <= v_next;
            if (pace_next) begin
                read_bank <= ~read_bank;
            end

            // Two-stage alignment of sync and blank with the RAM latency.
            active_d1 <= active0;
            hs_d1     <= hs0;
            vs_d1     <= vs0;
            blank_d1  <= ~active0;
            hs_q      <= hs_d1;
            vs_q      <= vs_d1;
            blank_q   <= blank_d1;
            rgb_q     <= active_d1 ? rb.data_read_row : 24'd0;

            case (state)
                ST_SCAN: begin
                    // Clear-after-read: write the address that was read one
                    // cycle ago. The RAM has already sampled it, so the read and
                    // the clear write never collide.
                    clr_we_q   <= active0;
                    clr_addr_q <= rb.address_read_row;
                    clr_bank_q <= read_bank;
                    if (h_count == '0 && v_count == V_CLR_A) begin
                        state   <= ST_CLR_A;
                        clr_cnt <= '0;
                    end else if (h_count == '0 && v_count == V_CLR_B) begin
                        state   <= ST_CLR_B;
                        clr_cnt <= '0;
                    end
                end
                ST_CLR_A, ST_CLR_B: begin
                    // Wipe a whole bank during vertical blanking. Both banks are
                    // clean before the next frame, whatever the drawer left behind.
                    clr_we_q   <= 1'b1;
                    clr_addr_q <= clr_cnt;
                    clr_bank_q <= (state == ST_CLR_B);
                    clr_cnt    <= clr_cnt + 9'd1;
                    if (clr_cnt == CLR_LAST) begin
                        state <= ST_SCAN;
                    end
                end
                default: begin
                    state    <= ST_SCAN;
                    clr_we_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_scanner.sv
// -----------------------------------------------------------------------------
// tb_row_scanner
//
// Directed bench for row_scanner. It uses a reduced timing (25 x 11) so that
// several whole frames fit in a short run. The row-buffer RAM model returns
// {bank, addr[8], addr[7:0]} spread over R/G/B, with one cycle of latency.
// -----------------------------------------------------------------------------
module tb_row_scanner;

    localparam int          H_ACTIVE = 16;
    localparam int          H_FP     = 2;
    localparam int          H_SYNC   = 4;
    localparam int          H_BP     = 3;
    localparam int          V_ACTIVE = 6;
    localparam int          V_FP     = 1;
    localparam int          V_SYNC   = 2;
    localparam int          V_BP     = 2;
    localparam logic [23:0] BG       = 24'h123456;
    localparam int          HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 25
    localparam int          VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 11
    localparam int          FRAME    = HT * VT;                           // 275

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] red, green, blue;
    logic       hsync, vsync, blank;

    int checks   = 0;
    int failures = 0;

    row_scanner_if bus ();

    row_scanner #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .BG_COLOR(BG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rb    (bus),
        .red   (red),
        .green (green),
        .blue  (blue),
        .hsync (hsync),
        .vsync (vsync),
        .blank (blank)
    );

    always #5 clk = ~clk;

    // Registered RAM model: red = bank, green = addr[8], blue = addr[7:0].
    always @(posedge clk) begin
        bus.data_read_row <= {7'd0, bus.read_buffer, 7'd0, bus.address_read_row};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs two frames from a fresh reset release. The current cycle is already
    // h=0 of line 0. Timing, pacing, scan data and clears are checked.
    task automatic run_frames(input string pfx);
        int swap_n = 0, scr_n = 0, both_n = 0, swap_bad = 0, first_swap = -1;
        int scr_c[2];
        int scr_k = 0, hs_first = -1, hs_len = 0, vs_first = -1, vs_len = 0;
        int clr_line[VT];
        int addr_bad = 0, bank_bad = 0, data_bad = 0, seq_bad = 0, clr_seq = 0, idle_clr = 0;
        logic [8:0] prev_addr = '0;
        int h, v, f;
        scr_c[0] = -1;
        scr_c[1] = -1;
        for (int i = 0; i < VT; i++) clr_line[i] = 0;

        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c > 0) @(negedge clk); else #1;
            h = c % HT;
            v = (c / HT) % VT;
            f = c / FRAME;
            if (bus.swap && bus.swap_screen) both_n++;
            if (bus.swap_screen) begin
                if (scr_k < 2) scr_c[scr_k] = c;
                scr_k++;
            end
            if (f == 0) begin
                if (bus.swap) begin
                    swap_n++;
                    if (first_swap < 0) first_swap = c;
                    if (h != 0) swap_bad++;
                end
                if (bus.swap_screen) scr_n++;
                if (v == 0 && !hsync) begin
                    if (hs_first < 0) hs_first = h;
                    hs_len++;
                end
                if (!vsync) begin
                    if (vs_first < 0) vs_first = c;
                    vs_len++;
                end
                if (bus.clear_we) begin
                    clr_line[v]++;
                    if (bus.data_clear_row !== BG) data_bad++;
                    if (v < V_ACTIVE) begin
                        if (bus.address_clear_row !== prev_addr) addr_bad++;
                        if (bus.clear_buffer !== bus.read_buffer) bank_bad++;
                    end else if (v <= V_ACTIVE + 1) begin
                        if (bus.clear_buffer !== (v == V_ACTIVE + 1)) bank_bad++;
                        if (bus.address_clear_row !== 9'(clr_seq % H_ACTIVE)) seq_bad++;
                        clr_seq++;
                    end else begin
                        idle_clr++;
                    end
                end
                // Pixel 5 of line 0 appears at h=7 and is read from bank 0.
                if (v == 0 && h == 7) begin
                    check({pfx, "blue_px5"}, 32'(blue), 32'h05);
                    check({pfx, "red_px5_bank"}, 32'(red), 32'h00);
                    check({pfx, "blank_px5"}, 32'(blank), 32'd0);
                end
                // The last active pixel of line 0, then the first blanked position.
                if (v == 0 && h == H_ACTIVE + 1) begin
                    check({pfx, "blue_last_px"}, 32'(blue), 32'(H_ACTIVE - 1));
                    check({pfx, "blank_last_px"}, 32'(blank), 32'd0);
                end
                if (v == 0 && h == H_ACTIVE + 2) begin
                    check({pfx, "rgb_past_active"}, {8'd0, red, green, blue}, 32'd0);
                    check({pfx, "blank_past_active"}, 32'(blank), 32'd1);
                end
                // Line 1 scans bank 1 after its swap.
                if (v == 1 && h == 5) begin
                    check({pfx, "red_line1_bank"}, 32'(red), 32'h01);
                    check({pfx, "blue_line1_px3"}, 32'(blue), 32'h03);
                end
            end
            prev_addr = bus.address_read_row;
        end

        check({pfx, "swap_count"}, swap_n, V_ACTIVE - 1);
        check({pfx, "screen_count"}, scr_n, 1);
        check({pfx, "swap_off_h0"}, swap_bad, 0);
        check({pfx, "first_swap_cycle"}, first_swap, 0);
        check({pfx, "swap_and_screen"}, both_n, 0);
        check({pfx, "screen_cycle"}, scr_c[0], (VT - 1) * HT);
        check({pfx, "frame_period"}, scr_c[1] - scr_c[0], FRAME);
        check({pfx, "hsync_first_h"}, hs_first, H_ACTIVE + H_FP + 2);
        check({pfx, "hsync_len"}, hs_len, H_SYNC);
        check({pfx, "vsync_first_cycle"}, vs_first, (V_ACTIVE + V_FP) * HT + 2);
        check({pfx, "vsync_len"}, vs_len, V_SYNC * HT);
        for (int l = 0; l < V_ACTIVE; l++)
            check($sformatf("%sclr_line%0d", pfx, l), clr_line[l], H_ACTIVE);
        check({pfx, "clr_bank0_line"}, clr_line[V_ACTIVE], H_ACTIVE);
        check({pfx, "clr_bank1_line"}, clr_line[V_ACTIVE + 1], H_ACTIVE);
        check({pfx, "clr_idle_lines"}, idle_clr, 0);
        check({pfx, "clr_addr_lag"}, addr_bad, 0);
        check({pfx, "clr_bank"}, bank_bad, 0);
        check({pfx, "clr_data"}, data_bad, 0);
        check({pfx, "clr_seq"}, seq_bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_swap", 32'(bus.swap), 32'd0);
        check("rst_read_buffer", 32'(bus.read_buffer), 32'd0);
        check("rst_clear_we", 32'(bus.clear_we), 32'd0);
        check("rst_rgb", {8'd0, red, green, blue}, 32'd0);
        reset = 1'b0;
        run_frames("f0_");

        // Move to line 3, h 10 of the third frame and reset there.
        repeat (3 * HT + 10 + 1) @(negedge clk);
        check("mid_addr", 32'(bus.address_read_row), 32'd10);
        check("mid_read_buffer", 32'(bus.read_buffer), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_read_buffer", 32'(bus.read_buffer), 32'd0);
        check("mrst_clear_we", 32'(bus.clear_we), 32'd0);
        check("mrst_addr", 32'(bus.address_read_row), 32'd0);
        check("mrst_swap", 32'(bus.swap), 32'd0);
        check("mrst_blank", 32'(blank), 32'd1);
        reset = 1'b0;
        run_frames("f1_");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/row_scanner.md
Name: row_scanner

Overview:
- Read-side counterpart to the row drawer.
- Generates display timing, one pixel per clk.
- Reads the double-buffered 24-bit row buffer that the drawer fills and drives RGB/sync/blank to the output DAC.
- Issues the `swap` / `swap_screen` pulses that pace the drawer, and clears each row to background after scan-out so the drawer always starts from a clean row.

Parameters:
- H_ACTIVE, 320, visible pixels per line (max 512, row address is 9 bits)
- H_FP, 8, horizontal front porch, clocks
- H_SYNC, 48, hsync pulse width, clocks
- H_BP, 24, horizontal back porch, clocks
- V_ACTIVE, 240, visible lines per frame
- V_FP, 3, vertical front porch, lines
- V_SYNC, 4, vsync pulse width, lines
- V_BP, 15, vertical back porch, lines
- BG_COLOR, 24'h000000, background written back on clear

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- address_read_row  out  9  row-buffer read address
- read_buffer  out  1  row-buffer bank being scanned out
- data_read_row  in  24  read data {R[23:16],G[15:8],B[7:0]}; registered RAM, 1-cycle latency
- address_clear_row  out  9  row-buffer write address for clears
- clear_buffer  out  1  bank targeted by the clear write
- clear_we  out  1  clear write enable
- data_clear_row  out  24  clear write data, constant BG_COLOR
- swap  out  1  1-clk pulse: drawer advances to next row
- swap_screen  out  1  1-clk pulse: drawer restarts at row 0
- draw_buffer  out  1  bank the drawer writes; always ~read_buffer
- red, green, blue  out  8 each  pixel colour
- hsync, vsync  out  1 each  active-low sync
- blank  out  1  high outside the active area

Behaviour:
- Timing:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (400).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (262).
  - h_count wraps H_TOTAL-1 -> 0 and increments v_count.
  - v_count wraps V_TOTAL-1 -> 0.
- Reset (synchronous):
  - h_count=v_count=0, read_buffer=0.
  - swap=swap_screen=clear_we=0; address outputs 0.
  - hsync=vsync=1, blank=1, rgb=0.
  - FSM state to SCAN.
  - Reset mid-frame restarts timing at (0,0). Buffer contents are not cleared until the next clear pass; stale pixels in the first frame are acceptable.
- Row pacing:
  - swap pulses when h_count==0 and v_count in 0..V_ACTIVE-2.
  - swap_screen pulses when h_count==0 and v_count==V_TOTAL-1.
  - swap and swap_screen are never high together.
  - read_buffer toggles on the cycle of either pulse. Line r scans out the bank the drawer filled during line r-1.
- Scan pipeline, active lines (v_count<V_ACTIVE, h_count<H_ACTIVE):
  - Stage 0: address_read_row=h_count.
  - Stage 1: data returns.
  - Stage 2: red/green/blue registered.
  - hsync, vsync and blank are delayed by the same 2 clocks so they align with the pixel.
  - Outside the active area rgb is 0.
- Clear-after-read:
  - In stage 1 of each active pixel: clear_we=1, address_clear_row=previous read address, clear_buffer=read_buffer.
  - Because the read sampled one cycle earlier, there is no read/write collision.
- FSM:
  - SCAN: normal operation.
  - CLR_A: entered at h_count==0, v_count==V_ACTIVE. Writes BG_COLOR to bank 0, addresses 0..H_ACTIVE-1, one per clk, then goes to SCAN.
  - CLR_B: same for bank 1 at v_count==V_ACTIVE+1.
  - Requires V_FP+V_SYNC+V_BP >= 3.
  - clear_we=0 in all other cycles.
- Sync:
  - hsync=0 for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync=0 for v_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - Both are before the 2-cycle delay.

Test Plan:
- Reset held 3 clks then released:
  - At release: hsync=vsync=blank=1, swap=0, read_buffer=0.
  - First swap at clk 0 of line 0.
  - First hsync low at h_count 328, lasting 48 clks.
- Free-run one frame:
  - Exactly 239 swap pulses and 1 swap_screen, at h_count 0 of line 261.
  - vsync low for 4 lines starting at line 243.
  - Frame period 104800 clks.
- RAM model returns data=address:
  - At h_count=5+2, blue=8'h05 with blank=0.
  - At h_count 322 (pixel 320 position), rgb=0 and blank=1.
- Active line:
  - clear_we high for exactly 320 clks per line.
  - address_clear_row lags address_read_row by 1.
  - clear_buffer equals that line's read_buffer.
  - data_clear_row=BG_COLOR.
- Line 240 and line 241:
  - Line 240: 320 clear writes to bank 0.
  - Line 241: 320 clear writes to bank 1.
  - No clear writes on lines 242..261.
- Assert reset at line 100, h_count 50:
  - Next clk: counters 0, read_buffer=0, clear_we=0.
  - Timing resumes identical to the first frame.
